// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle for the two register-file writeback sources.
// Source 0 is the ALU and source 1 is the load unit.
// The master side drives valid/rd/data and the slave side answers with ready.
interface regfile_wb_arbiter_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            wb0_valid;
    logic [AW-1:0]   wb0_rd;
    logic [XLEN-1:0] wb0_data;
    logic            wb0_ready;
    logic            wb1_valid;
    logic [AW-1:0]   wb1_rd;
    logic [XLEN-1:0] wb1_data;
    logic            wb1_ready;

    modport master (
        output wb0_valid, wb0_rd, wb0_data,
        input  wb0_ready,
        output wb1_valid, wb1_rd, wb1_data,
        input  wb1_ready
    );

    modport slave (
        input  wb0_valid, wb0_rd, wb0_data,
        output wb0_ready,
        input  wb1_valid, wb1_rd, wb1_data,
        output wb1_ready
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with a per-register busy scoreboard.
// Build option: define WBARB_FIXED_PRIO_EN to let the load source always win a
// conflict; left undefined, conflicts are resolved round-robin.
module regfile_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic                 Clk,
    input  logic                 Rst,
    regfile_wb_arbiter_if.slave  wb,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_rd,
    input  logic [AW-1:0]        q_rs1,
    input  logic [AW-1:0]        q_rs2,
    output logic                 q_busy1,
    output logic                 q_busy2,
    output logic                 rf_RegWrite,
    output logic [AW-1:0]        rf_rd,
    output logic [XLEN-1:0]      rf_wdata,
    output logic [NREG-1:0]      busy_vec
);
    // Purpose: grant one of two writeback sources per cycle onto the RF write port.
    // Latency: one cycle from the accepting edge to registered RF write outputs.
    // Backpressure: the losing source sees ready=0 and must hold its request.

    logic            gnt0, gnt1;
    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_rd_q, rf_rd_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic [NREG-1:0] busy_q, busy_d;

`ifdef WBARB_FIXED_PRIO_EN
    // Grant: the load source always wins a conflict.
    always_comb begin
        gnt1 = wb.wb1_valid;
        gnt0 = wb.wb0_valid & ~wb.wb1_valid;
    end
`else
    logic prio_q, prio_d;

    // Grant: a lone requester wins; on conflict the source named by prio wins.
    always_comb begin
        gnt0 = wb.wb0_valid & (~wb.wb1_valid | ~prio_q);
        gnt1 = wb.wb1_valid & (~wb.wb0_valid |  prio_q);
    end

    // Priority pointer: after serving a source, favour the other one.
    always_comb begin
        prio_d = prio_q;
        if (gnt0) begin
            prio_d = 1'b1;
        end else if (gnt1) begin
            prio_d = 1'b0;
        end
    end

    // Priority register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`endif

    assign wb.wb0_ready = gnt0;
    assign wb.wb1_ready = gnt1;

    // Write stage: capture the granted request; writes to x0 are swallowed here.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_wdata_d = rf_wdata_q;
        if (gnt0) begin
            rf_we_d    = (wb.wb0_rd != '0);
            rf_rd_d    = wb.wb0_rd;
            rf_wdata_d = wb.wb0_data;
        end else if (gnt1) begin
            rf_we_d    = (wb.wb1_rd != '0);
            rf_rd_d    = wb.wb1_rd;
            rf_wdata_d = wb.wb1_data;
        end
    end

    // Scoreboard: clear on RF commit, then set on issue so a younger writer wins.
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q) begin
            busy_d[rf_rd_q] = 1'b0;
        end
        if (iss_valid && (iss_rd != '0)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Output and scoreboard registers; reset drops any pending write.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
            busy_q     <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
            busy_q     <= busy_d;
        end
    end

    assign rf_RegWrite = rf_we_q;
    assign rf_rd       = rf_rd_q;
    assign rf_wdata    = rf_wdata_q;
    assign busy_vec    = busy_q;
    assign q_busy1     = busy_q[q_rs1];
    assign q_busy2     = busy_q[q_rs2];
endmodule
